// File: rtl/gps_nmea_rx_if.sv
// Host-side byte stream of gps_nmea_rx: FIFO head byte with a valid/ready handshake.
// master = byte producer (gps_nmea_rx), slave = host consumer.
interface gps_nmea_rx_if;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/gps_nmea_rx.sv
// ZED-F9P receive path: 8N1 UART, NMEA sentence framer and FWFT byte FIFO.
// Optional macro GPS_NMEA_CHECKSUM_EN enables the XOR checksum compare at <LF>.
module gps_nmea_rx #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 38400,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_LEN    = 82
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gps_rx,
    gps_nmea_rx_if.master     rd,
    output logic              sentence_done,
    output logic              sentence_err,
    output logic              framing_err,
    output logic              overflow
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int LW           = $clog2(MAX_LEN + 1);

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;

    typedef enum logic [2:0] {U_IDLE = 3'd0, U_START = 3'd1, U_DATA = 3'd2,
                              U_STOP = 3'd3, U_BREAK = 3'd4} u_state_t;
    typedef enum logic [2:0] {P_HUNT = 3'd0, P_BODY = 3'd1, P_CK1 = 3'd2,
                              P_CK2 = 3'd3, P_CR = 3'd4, P_LF = 3'd5} p_state_t;

    function automatic logic hex_valid(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46));
    endfunction

`ifdef GPS_NMEA_CHECKSUM_EN
    function automatic logic [3:0] hex_value(input logic [7:0] c);
        if (c <= 8'h39) return c[3:0];
        else            return c[3:0] + 4'd9;
    endfunction

    logic [7:0] csum_q, csum_d, ck_q, ck_d;
`endif

    logic          sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
    u_state_t      u_state_q, u_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_fall_s, rx_byte_s, frame_s;

    p_state_t      p_state_q, p_state_d;
    logic [LW-1:0] len_q, len_d;
    logic          push_q, push_d, done_q, done_d, err_q, err_d, ferr_q, ferr_d;
    logic [7:0]    push_data_q, push_data_d;
    logic          is_dollar_s, is_star_s, is_cr_s, is_lf_s, hex_ok_s, len_full_s, csum_ok_s;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic          rd_valid_s, full_s, pop_s, wr_en_s, drop_s;

    // Synchroniser chain; all stages clear to 0 so a line already low after reset never looks like an edge.
    always_comb begin
        sync1_d   = gps_rx;
        sync2_d   = sync1_q;
        rx_prev_d = sync2_q;
    end

    assign rx_fall_s = rx_prev_q & ~sync2_q;

    // UART next-state and bit-timing datapath.
    always_comb begin
        u_state_d = u_state_q;
        cnt_d     = cnt_q + CW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        case (u_state_q)
            U_IDLE: begin
                cnt_d = '0;
                if (rx_fall_s) u_state_d = U_START;
                else           u_state_d = U_IDLE;
            end
            U_START: begin
                if (cnt_q == CW'(HALF_BIT - 1)) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    if (!sync2_q) u_state_d = U_DATA;
                    else          u_state_d = U_IDLE;
                end else begin
                    u_state_d = U_START;
                end
            end
            U_DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) u_state_d = U_STOP;
                    else               u_state_d = U_DATA;
                end else begin
                    u_state_d = U_DATA;
                end
            end
            U_STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (sync2_q) u_state_d = U_IDLE;
                    else         u_state_d = U_BREAK;
                end else begin
                    u_state_d = U_STOP;
                end
            end
            U_BREAK: begin
                cnt_d = '0;
                if (sync2_q) u_state_d = U_IDLE;
                else         u_state_d = U_BREAK;
            end
            default: begin
                cnt_d     = '0;
                u_state_d = U_IDLE;
            end
        endcase
    end

    // UART outputs: byte strobe or framing error in the stop-sample cycle.
    always_comb begin
        rx_byte_s = 1'b0;
        frame_s   = 1'b0;
        if ((u_state_q == U_STOP) && (cnt_q == CW'(CLKS_PER_BIT - 1))) begin
            rx_byte_s = sync2_q;
            frame_s   = ~sync2_q;
        end else begin
            rx_byte_s = 1'b0;
            frame_s   = 1'b0;
        end
    end

    assign is_dollar_s = (shift_q == CH_DOLLAR);
    assign is_star_s   = (shift_q == CH_STAR);
    assign is_cr_s     = (shift_q == CH_CR);
    assign is_lf_s     = (shift_q == CH_LF);
    assign hex_ok_s    = hex_valid(shift_q);
    assign len_full_s  = (len_q == LW'(MAX_LEN));
`ifdef GPS_NMEA_CHECKSUM_EN
    assign csum_ok_s   = (ck_q == csum_q);
`else
    assign csum_ok_s   = 1'b1;
`endif

    // Parser next state; a dropped push or a framing error abandons the sentence.
    always_comb begin
        p_state_d = p_state_q;
        if (drop_s || frame_s) begin
            p_state_d = P_HUNT;
        end else if (rx_byte_s) begin
            if (is_dollar_s)                p_state_d = P_BODY;
            else if (p_state_q == P_HUNT)   p_state_d = P_HUNT;
            else if (len_full_s)            p_state_d = P_HUNT;
            else begin
                case (p_state_q)
                    P_BODY:  p_state_d = is_star_s ? P_CK1 : P_BODY;
                    P_CK1:   p_state_d = hex_ok_s ? P_CK2 : P_HUNT;
                    P_CK2:   p_state_d = hex_ok_s ? P_CR : P_HUNT;
                    P_CR:    p_state_d = is_cr_s ? P_LF : P_HUNT;
                    P_LF:    p_state_d = P_HUNT;
                    default: p_state_d = P_HUNT;
                endcase
            end
        end else begin
            p_state_d = p_state_q;
        end
    end

    // Parser outputs: push request, status pulses, length and checksum bookkeeping.
    always_comb begin
        push_d      = 1'b0;
        push_data_d = shift_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        len_d       = len_q;
        ferr_d      = frame_s;
`ifdef GPS_NMEA_CHECKSUM_EN
        csum_d      = csum_q;
        ck_d        = ck_q;
`endif
        if (frame_s) begin
            err_d = (p_state_q != P_HUNT);
        end else if (rx_byte_s) begin
            if (is_dollar_s) begin
                err_d  = (p_state_q != P_HUNT);
                push_d = 1'b1;
                len_d  = LW'(1);
`ifdef GPS_NMEA_CHECKSUM_EN
                csum_d = 8'h00;
`endif
            end else if (p_state_q == P_HUNT) begin
                push_d = 1'b0;
            end else if (len_full_s) begin
                err_d = 1'b1;
            end else begin
                len_d = len_q + LW'(1);
                case (p_state_q)
                    P_BODY: begin
                        push_d = 1'b1;
`ifdef GPS_NMEA_CHECKSUM_EN
                        if (!is_star_s) csum_d = csum_q ^ shift_q;
                        else            csum_d = csum_q;
`endif
                    end
                    P_CK1: begin
                        push_d = hex_ok_s;
                        err_d  = ~hex_ok_s;
`ifdef GPS_NMEA_CHECKSUM_EN
                        ck_d   = {hex_value(shift_q), ck_q[3:0]};
`endif
                    end
                    P_CK2: begin
                        push_d = hex_ok_s;
                        err_d  = ~hex_ok_s;
`ifdef GPS_NMEA_CHECKSUM_EN
                        ck_d   = {ck_q[7:4], hex_value(shift_q)};
`endif
                    end
                    P_CR: begin
                        push_d = is_cr_s;
                        err_d  = ~is_cr_s;
                    end
                    P_LF: begin
                        push_d = is_lf_s;
                        done_d = is_lf_s & csum_ok_s;
                        err_d  = ~(is_lf_s & csum_ok_s);
                    end
                    default: err_d = 1'b1;
                endcase
            end
        end else begin
            push_d = 1'b0;
        end
    end

    // FIFO pointer control; a full push survives only alongside a pop.
    always_comb begin
        pop_s    = rd_valid_s & rd.rd_ready;
        wr_en_s  = push_q & (~full_s | pop_s);
        drop_s   = push_q & full_s & ~pop_s;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_s) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        else         wr_ptr_d = wr_ptr_q;
        if (pop_s)   rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        else         rd_ptr_d = rd_ptr_q;
        ovf_d = ovf_q | drop_s;
    end

    assign rd_valid_s  = (wr_ptr_q != rd_ptr_q);
    assign full_s      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd.rd_valid = rd_valid_s;
    assign rd.rd_data  = rd_valid_s ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;

    // A drop is only known in the write cycle, so it overrides the registered pulse there.
    assign sentence_done = done_q & ~drop_s;
    assign sentence_err  = err_q | drop_s;
    assign framing_err   = ferr_q;
    assign overflow      = ovf_q;

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            rx_prev_q   <= 1'b0;
            u_state_q   <= U_IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            p_state_q   <= P_HUNT;
            len_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= 8'h00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ferr_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ovf_q       <= 1'b0;
`ifdef GPS_NMEA_CHECKSUM_EN
            csum_q      <= 8'h00;
            ck_q        <= 8'h00;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            rx_prev_q   <= rx_prev_d;
            u_state_q   <= u_state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            p_state_q   <= p_state_d;
            len_q       <= len_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ferr_q      <= ferr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ovf_q       <= ovf_d;
`ifdef GPS_NMEA_CHECKSUM_EN
            csum_q      <= csum_d;
            ck_q        <= ck_d;
`endif
        end
    end

    // FIFO storage, not reset: rd_data is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en_s) mem_q[wr_ptr_q[AW-1:0]] <= push_data_q;
    end
endmodule

// File: doc/gps_nmea_rx.md
# gps_nmea_rx

Receive-side stage for the U-Blox ZED-F9P GPS link. It deserialises the 8N1 UART stream on `gps_rx` and frames NMEA sentences (`$…*hh<CR><LF>`), validating each sentence's checksum. Sentence bytes go into a small first-word-fall-through FIFO that the host-facing logic drains over a valid/ready handshake. It sits directly downstream of the GPS pin interface, between `gps_rx` and the host data path.

## Interface
- `CLK_HZ`, 100000000, main clock frequency.
- `BAUD`, 38400, GPS UART rate. The block derives `CLKS_PER_BIT = CLK_HZ/BAUD` (truncating; 2604 at defaults).
- `FIFO_DEPTH`, 16, byte FIFO depth. Must be a power of 2, at least 4.
- `MAX_LEN`, 82, maximum sentence length counted from `$` through `<LF>`.

Ports:
- `clk` in 1: 100 MHz main clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `gps_rx` in 1: asynchronous serial input from the GPS. Idle high.
- `rd_data` out 8: FIFO head byte. Valid while `rd_valid` is high.
- `rd_valid` out 1: FIFO not empty.
- `rd_ready` in 1: consumer accepts the head byte.
- `sentence_done` out 1: 1-cycle pulse. A complete, valid sentence ending in `<LF>` has been pushed.
- `sentence_err` out 1: 1-cycle pulse. The sentence in progress is bad, and the host must discard bytes back to its last `$`.
- `framing_err` out 1: 1-cycle pulse. The stop bit was sampled low.
- `overflow` out 1: sticky flag. A byte was dropped because the FIFO was full. Cleared only by `reset`.

## Operation
- **Input synchroniser:** `gps_rx` passes through a 2-FF synchroniser. The UART uses only the synchronised value.
- **UART FSM:**
  - `U_IDLE`: waits for a falling edge.
  - `U_START`: after `CLKS_PER_BIT/2` clocks, samples the line. If low, goes to `U_DATA`. If high, treats it as a glitch and returns to `U_IDLE`.
  - `U_DATA`: takes 8 samples spaced `CLKS_PER_BIT` apart, LSB first.
  - `U_STOP`: samples once more, `CLKS_PER_BIT` later.
    - Stop bit high: strobes `rx_byte` for 1 cycle and returns to `U_IDLE`.
    - Stop bit low: pulses `framing_err`, discards the byte, and goes to `U_BREAK` (waits for the line high, then `U_IDLE`).
- **Parser FSM:** the parser acts only on `rx_byte` strobes.
  - `P_HUNT`: drops every byte except `$`. On `$`, pushes it, clears `csum` and the length counter, and goes to `P_BODY`.
  - `P_BODY`: pushes each byte. On `*`, goes to `P_CK1`. Otherwise sets `csum ^= byte`. The `$` and `*` bytes are excluded from `csum`.
  - `P_CK1`, `P_CK2`: push one hex digit each. Legal digits are `0-9` and `A-F` (uppercase only).
  - `P_CR`: expects `<CR>`.
  - `P_LF`: expects `<LF>`. On `<LF>`, pushes it, pulses `sentence_done` (or `sentence_err` on checksum mismatch), and returns to `P_HUNT`.
- **Errors:** each of the following pulses `sentence_err`, and the offending byte is not pushed:
  - an illegal hex digit;
  - a missing `<CR>` or `<LF>`;
  - length exceeding `MAX_LEN`;
  - a `framing_err` while outside `P_HUNT`;
  - an overflow drop.

  After the error the parser returns to `P_HUNT`. Exception: a `$` seen outside `P_HUNT` pulses `sentence_err`, is pushed as the start of a new sentence, and the parser goes to `P_BODY`.
- **FIFO:**
  - First-word-fall-through; `rd_data` shows the head byte.
  - Pop occurs when `rd_valid && rd_ready`.
  - Push when full is accepted if a pop happens in the same cycle.
  - Otherwise a push when full drops the byte, sets `overflow`, and raises `sentence_err`.
  - Pointers are `$clog2(FIFO_DEPTH)+1` bits and wrap naturally.

## Timing
- **Reset values:** `rd_valid`=0, `rd_data`=0, `sentence_done`=0, `sentence_err`=0, `framing_err`=0, `overflow`=0. The UART returns to `U_IDLE`, the parser to `P_HUNT`, and the FIFO is emptied.
- Reset mid-byte or mid-sentence abandons the byte or sentence. The block must then see a fresh falling edge.
- **Edge-to-start latency:** a falling edge on the pin is seen 2 clocks later.
- **Sample points:** the start bit is sampled `CLKS_PER_BIT/2` clocks after the edge is seen. Each later sample follows `CLKS_PER_BIT` clocks after the previous one.
- **Byte latency:**
  - `rx_byte` at cycle N (the stop-sample cycle).
  - FIFO write at N+1. `sentence_done`/`sentence_err` pulse in the same cycle N+1.
  - `rd_valid` high at N+2 if the FIFO was empty.
- **Pulse rule:** `sentence_done` and `sentence_err` are never asserted together.
- **Back-to-back bytes:** the UART must accept a start edge in the cycle immediately after the stop sample.

## Configuration
- `GPS_NMEA_CHECKSUM_EN` defined:
  - `csum` is accumulated.
  - At `<LF>`, the received hex value is compared with `csum`.
  - On mismatch, `sentence_err` pulses instead of `sentence_done`.
- `GPS_NMEA_CHECKSUM_EN` undefined:
  - The `csum` register and comparator are removed.
  - The hex-digit format check is still applied.
  - `sentence_done` pulses on every well-formed `<LF>`.

## Test plan
- **Valid sentence:** send `$GPTXT*4F\r\n`. Expect 11 bytes out in order, exactly 1 `sentence_done` pulse, and no error pulses.
- **Bad checksum:** send `$GPTXT*4E\r\n`. With the macro: `sentence_err` pulses in the `<LF>` write cycle and `sentence_done` does not. Without the macro: `sentence_done` pulses.
- **Leading garbage and glitch:** send `AB$GPTXT*4F\r\n` preceded by a 1000-clock low glitch. Expect no byte from the glitch and exactly the 11 bytes starting at `$`.
- **Framing error:** send `$GP`, then a byte with its stop bit low. Expect 1 `framing_err` pulse, 1 `sentence_err` pulse, the bad byte absent, and the parser in `P_HUNT`.
- **Overflow:** hold `rd_ready`=0 and send a 17-byte sentence with `FIFO_DEPTH`=16. Expect 16 bytes held, `overflow`=1, and 1 `sentence_err` pulse. Then raise `rd_ready` and expect 16 bytes to drain.
- **Reset mid-byte:** assert `reset` for 1 cycle during `U_DATA`. Expect all outputs at their reset values and the next full sentence received correctly.
